// File: rtl/sc_or_acc_pkg.sv
// ============================================================================
// sc_or_acc_pkg : shared FSM state encoding and default widths for sc_or_acc
// Revision      : 1.0
// ============================================================================
`default_nettype none

package sc_or_acc_pkg;

  localparam int unsigned DEF_DATAWIDTH  = 8;
  localparam int unsigned DEF_COUNTWIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sc_or_acc_or_c.sv
// ============================================================================
// sc_or_acc_or_c : combinational bitwise OR stage (SC_OR_C) feeding the accumulator
// Revision       : 1.0
// ============================================================================
`default_nettype none

module sc_or_acc_or_c #(
  parameter int unsigned NUMBER_DATAWIDTH = 8
) (
  input  logic [NUMBER_DATAWIDTH-1:0] a_in,
  input  logic [NUMBER_DATAWIDTH-1:0] b_in,
  output logic [NUMBER_DATAWIDTH-1:0] z_out
);

  assign z_out = a_in | b_in;

endmodule

`default_nettype wire

// File: rtl/sc_or_acc.sv
// ============================================================================
// sc_or_acc : frame-level OR accumulator with valid/ready result port.
//             Optional beat counter built when SC_OR_ACC_COUNT_EN is defined.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module sc_or_acc
  import sc_or_acc_pkg::*;
#(
  parameter int unsigned NUMBER_DATAWIDTH  = DEF_DATAWIDTH,
  parameter int unsigned NUMBER_COUNTWIDTH = DEF_COUNTWIDTH
) (
  input  logic                         SC_OR_ACC_CLOCK_50,
  input  logic                         SC_OR_ACC_RESET_InHigh,
  input  logic [NUMBER_DATAWIDTH-1:0]  SC_OR_ACC_data_In,
  input  logic                         SC_OR_ACC_valid_In,
  input  logic                         SC_OR_ACC_last_In,
  output logic                         SC_OR_ACC_ready_Out,
  output logic [NUMBER_DATAWIDTH-1:0]  SC_OR_ACC_z_Out,
  output logic                         SC_OR_ACC_valid_Out,
  input  logic                         SC_OR_ACC_ready_In
`ifdef SC_OR_ACC_COUNT_EN
  ,
  output logic [NUMBER_COUNTWIDTH-1:0] SC_OR_ACC_count_Out
`endif
);

  state_e                      state_q, state_d;
  logic [NUMBER_DATAWIDTH-1:0] acc_q, acc_d;
  logic [NUMBER_DATAWIDTH-1:0] or_operand;
  logic [NUMBER_DATAWIDTH-1:0] or_result;
  logic                        in_beat;
  logic                        out_beat;

  if (NUMBER_DATAWIDTH < 1 || NUMBER_COUNTWIDTH < 1) begin : g_cfg_invalid
  end

  // Handshake flags come only from the registered state, never from inputs.
  assign SC_OR_ACC_ready_Out = (state_q == IDLE) || (state_q == ACCUM);
  assign SC_OR_ACC_valid_Out = (state_q == HOLD);
  assign SC_OR_ACC_z_Out     = acc_q;

  assign in_beat  = SC_OR_ACC_valid_In  & SC_OR_ACC_ready_Out;
  assign out_beat = SC_OR_ACC_valid_Out & SC_OR_ACC_ready_In;

  // First word of a frame must not pick up stale accumulator bits.
  assign or_operand = (state_q == IDLE) ? '0 : acc_q;

  sc_or_acc_or_c #(
    .NUMBER_DATAWIDTH(NUMBER_DATAWIDTH)
  ) u_or_c (
    .a_in  (SC_OR_ACC_data_In),
    .b_in  (or_operand),
    .z_out (or_result)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (in_beat) begin
          acc_d   = or_result;
          state_d = SC_OR_ACC_last_In ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_beat) begin
          acc_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge SC_OR_ACC_CLOCK_50) begin
    if (SC_OR_ACC_RESET_InHigh) begin
      state_q <= IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

`ifdef SC_OR_ACC_COUNT_EN
  logic [NUMBER_COUNTWIDTH-1:0] count_q, count_d;

  assign SC_OR_ACC_count_Out = count_q;

  always_comb begin
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (in_beat) begin
          count_d = NUMBER_COUNTWIDTH'(1);
        end
      end
      ACCUM: begin
        // Saturate at all-ones rather than wrapping on long frames.
        if (in_beat && (count_q != '1)) begin
          count_d = count_q + NUMBER_COUNTWIDTH'(1);
        end
      end
      HOLD: begin
        if (out_beat) begin
          count_d = '0;
        end
      end
      default: begin
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge SC_OR_ACC_CLOCK_50) begin
    if (SC_OR_ACC_RESET_InHigh) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sc_or_acc.sv
// ============================================================================
// tb_sc_or_acc : directed + randomized self-checking bench for sc_or_acc
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_sc_or_acc;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          last_in;
  logic          ready_out;
  logic [DW-1:0] z_out;
  logic          valid_out;
  logic          ready_in;
`ifdef SC_OR_ACC_COUNT_EN
  logic [CW-1:0] count_out;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: the words of the current frame and whether it is complete.
  logic [DW-1:0] m_frame[$];
  bit            m_done;

  always #5 clk = ~clk;

  sc_or_acc #(
    .NUMBER_DATAWIDTH (DW),
    .NUMBER_COUNTWIDTH(CW)
  ) dut (
    .SC_OR_ACC_CLOCK_50    (clk),
    .SC_OR_ACC_RESET_InHigh(rst),
    .SC_OR_ACC_data_In     (data_in),
    .SC_OR_ACC_valid_In    (valid_in),
    .SC_OR_ACC_last_In     (last_in),
    .SC_OR_ACC_ready_Out   (ready_out),
    .SC_OR_ACC_z_Out       (z_out),
    .SC_OR_ACC_valid_Out   (valid_out),
    .SC_OR_ACC_ready_In    (ready_in)
`ifdef SC_OR_ACC_COUNT_EN
    ,
    .SC_OR_ACC_count_Out   (count_out)
`endif
  );

  function automatic logic [DW-1:0] model_or();
    logic [DW-1:0] r = '0;
    foreach (m_frame[i]) r = r | m_frame[i];
    return r;
  endfunction

  function automatic int model_count();
    int max_cnt = (1 << CW) - 1;
    return (m_frame.size() > max_cnt) ? max_cnt : m_frame.size();
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ready_Out", 32'(ready_out), 32'(!m_done));
    chk("valid_Out", 32'(valid_out), 32'(m_done));
    chk("z_Out", 32'(z_out), 32'(model_or()));
`ifdef SC_OR_ACC_COUNT_EN
    chk("count_Out", 32'(count_out), 32'(model_count()));
`endif
  endtask

  // One clock: drive at negedge, advance the model at the edge, check just after.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit l, input bit r,
                      input bit rs = 1'b0);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    last_in  = l;
    ready_in = r;
    rst      = rs;
    @(posedge clk);
    if (rs) begin
      m_frame.delete();
      m_done = 1'b0;
    end else if (!m_done && v) begin
      m_frame.push_back(d);
      if (l) m_done = 1'b1;
    end else if (m_done && r) begin
      m_frame.delete();
      m_done = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; data_in = '0; valid_in = 1'b0; last_in = 1'b0; ready_in = 1'b0;
    m_done = 1'b0;

    // Reset held for two clocks
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    chk("reset_z", 32'(z_out), 32'h0);

    // Multi-beat frame
    step(1, 8'h01, 0, 1);
    step(1, 8'h10, 0, 1);
    step(1, 8'h80, 1, 0);
    chk("multi_z", 32'(z_out), 32'h91);
`ifdef SC_OR_ACC_COUNT_EN
    chk("multi_count", 32'(count_out), 32'd3);
`endif
    step(0, 8'h00, 0, 1);
    chk("multi_cleared", 32'(z_out), 32'h0);

    // Backpressure on a single-beat frame; valid pulses in HOLD are ignored
    step(1, 8'hA5, 1, 0);
    for (int i = 0; i < 5; i++) step(i[0], 8'h5A, 1, 0);
    chk("bp_z", 32'(z_out), 32'hA5);
    step(0, 8'h00, 0, 1);

    // Frame with idle gaps
    step(1, 8'h03, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 8'hFF, 1, 1);
    step(1, 8'h0C, 1, 0);
    chk("gap_z", 32'(z_out), 32'h0F);
    step(0, 8'h00, 0, 1);

    // Reset mid-frame discards the partial result
    step(1, 8'hF0, 0, 1);
    step(1, 8'hFF, 1, 1, 1);
    step(1, 8'h0F, 1, 0);
    chk("rst_mid_z", 32'(z_out), 32'h0F);
    step(0, 8'h00, 0, 1);

    // Five-beat frame exceeds a 2-bit counter
    for (int i = 0; i < 5; i++) step(1, 8'(1 << i), (i == 4), 0);
    chk("sat_z", 32'(z_out), 32'h1F);
`ifdef SC_OR_ACC_COUNT_EN
    chk("sat_count", 32'(count_out), 32'd3);
`endif
    step(0, 8'h00, 0, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
